// File: rtl/pinwheel_pkg.sv
// Shared definitions for the pinwheel hart scheduler.
//   hart_state_e  : per-hart scheduling state
//   HPC_*         : field layout of a hart-tagged PC word {5'b0, hart[2:0], pc[23:0]}
//   RESET_PC      : default HPC loaded into hart 0 out of reset
//   make_hpc      : packs a hart index and PC into an HPC word
package pinwheel_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READY    = 2'd1,
    INFLIGHT = 2'd2,
    HALTPEND = 2'd3
  } hart_state_e;

  localparam int HPC_HART_LSB  = 24;
  localparam int HPC_PC_BITS   = 24;
  localparam int HPC_HART_BITS = 3;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  function automatic logic [31:0] make_hpc(input logic [HPC_HART_BITS-1:0] hart,
                                           input logic [HPC_PC_BITS-1:0]   pc);
    return {{(32 - HPC_HART_LSB - HPC_HART_BITS){1'b0}}, hart, pc};
  endfunction

endpackage

// File: rtl/pinwheel_rr_pick.sv
// Combinational round-robin picker.
//   req : one bit per hart that may be issued this cycle
//   ptr : last granted index; the search starts at ptr+1 and wraps
//   gnt : one-hot grant (all zero when nothing requested)
//   idx : index of the granted hart
//   any : a grant was made
module pinwheel_rr_pick
  import pinwheel_pkg::*;
#(
  parameter  int HARTS = 8,
  localparam int HW    = $clog2(HARTS)
) (
  input  logic [HARTS-1:0] req,
  input  logic [HW-1:0]    ptr,
  output logic [HARTS-1:0] gnt,
  output logic [HW-1:0]    idx,
  output logic             any
);

  logic [HW-1:0] cand;

  // HARTS is a power of two, so HW-bit addition wraps the search for free;
  // the last candidate visited is ptr itself.
  always_comb begin
    cand = '0;
    idx  = '0;
    any  = 1'b0;
    for (int i = 1; i <= HARTS; i++) begin
      cand = ptr + HW'(i);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    gnt = any ? (HARTS'(1) << idx) : '0;
  end

endmodule

// File: rtl/pinwheel_hart_sched.sv
// Round-robin hart scheduler for the pinwheel barrel core.
//   clock, reset_n                  : clock, asynchronous active-low reset
//   issue_valid, issue_hpc          : registered issue to stage A (0 = bubble)
//   ret_valid, ret_hpc              : next HPC from the core for the oldest tracked issue
//   dbg_start_*                     : start a hart at a PC (valid/ready handshake)
//   dbg_halt_valid, dbg_halt_hart   : halt request, always accepted
//   running                         : per-hart "not IDLE", registered
//   collision                       : sticky, a cross-hart return was dropped
//   issue_count                     : number of non-bubble issues, wraps
module pinwheel_hart_sched #(
  parameter int          HARTS    = 8,
  parameter logic [31:0] RESET_PC = pinwheel_pkg::RESET_PC,
  parameter int          RET_LAT  = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic             issue_valid,
  output logic [31:0]      issue_hpc,
  input  logic             ret_valid,
  input  logic [31:0]      ret_hpc,
  input  logic             dbg_start_valid,
  output logic             dbg_start_ready,
  input  logic [2:0]       dbg_start_hart,
  input  logic [23:0]      dbg_start_pc,
  input  logic             dbg_halt_valid,
  input  logic [2:0]       dbg_halt_hart,
  output logic [HARTS-1:0] running,
  output logic             collision,
  output logic [31:0]      issue_count
);
  import pinwheel_pkg::*;

  localparam int HW = $clog2(HARTS);

  hart_state_e      st     [HARTS];
  hart_state_e      st_nxt [HARTS];
  logic [23:0]      pc     [HARTS];
  logic [23:0]      pc_nxt [HARTS];
  logic [HW-1:0]    last_q;

  // Source tracker: entry 0 is the pick being driven next cycle, the
  // last entry is the issue the core is returning for now.
  logic             src_vld  [RET_LAT];
  logic [HW-1:0]    src_hart [RET_LAT];

  logic [HARTS-1:0] req;
  logic [HARTS-1:0] gnt;
  logic [HW-1:0]    pick_idx;
  logic             pick_any;

  logic             head_vld;
  logic [HW-1:0]    head_hart;
  logic [2:0]       ret_tgt_f;
  logic [HW-1:0]    ret_tgt;
  logic [23:0]      ret_pc;
  logic             tgt_ok, ret_act, ret_stop, ret_self, ret_cross, ret_drop;
  logic             start_ok, start_ready, start_fire;
  logic [HW-1:0]    start_idx;
  logic             unused_hpc_top;

  assign unused_hpc_top = ^ret_hpc[31:HPC_HART_LSB+3];

  // A hart being halted this cycle is withheld from the pick so the halt
  // returns it straight to IDLE instead of racing an issue.
  always_comb begin
    req = '0;
    for (int h = 0; h < HARTS; h++)
      req[h] = (st[h] == READY) && !(dbg_halt_valid && dbg_halt_hart == 3'(h));
  end

  pinwheel_rr_pick #(.HARTS(HARTS)) u_pick (
    .req (req),
    .ptr (last_q),
    .gnt (gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign head_vld  = src_vld[RET_LAT-1];
  assign head_hart = src_hart[RET_LAT-1];
  assign ret_tgt_f = ret_hpc[HPC_HART_LSB +: 3];
  assign ret_tgt   = ret_tgt_f[HW-1:0];
  assign ret_pc    = ret_hpc[HPC_PC_BITS-1:0];
  assign tgt_ok    = 32'(ret_tgt_f) < HARTS;
  assign ret_act   = ret_valid && head_vld;
  assign ret_stop  = (ret_pc == '0);
  assign ret_self  = tgt_ok && (ret_tgt == head_hart);
  // Cross-hart jump only lands on an IDLE hart; anything else (busy or
  // nonexistent target) is dropped and flagged.
  assign ret_cross = ret_act && !ret_stop && !ret_self && tgt_ok && (st[ret_tgt] == IDLE);
  assign ret_drop  = ret_act && !ret_stop && !ret_self && !ret_cross;

  assign start_ok    = 32'(dbg_start_hart) < HARTS;
  assign start_idx   = dbg_start_hart[HW-1:0];
  assign start_ready = start_ok && (st[start_idx] == IDLE)
                       && !(ret_cross && ret_tgt == start_idx)
                       && !(dbg_halt_valid && dbg_halt_hart == dbg_start_hart);
  assign start_fire      = dbg_start_valid && start_ready;
  assign dbg_start_ready = start_ready;

  // Per-hart next state. Pick, return and start touch disjoint harts by
  // construction (READY / INFLIGHT-or-HALTPEND / IDLE); halt is applied
  // last, on the state those events produce.
  always_comb begin
    for (int h = 0; h < HARTS; h++) begin
      st_nxt[h] = st[h];
      pc_nxt[h] = pc[h];
      if (gnt[h])
        st_nxt[h] = INFLIGHT;
      if (ret_act && head_hart == HW'(h)) begin
        if (ret_stop || !ret_self || st[h] == HALTPEND) begin
          st_nxt[h] = IDLE;
        end else begin
          st_nxt[h] = READY;
          pc_nxt[h] = ret_pc;
        end
      end
      if (ret_cross && ret_tgt == HW'(h)) begin
        st_nxt[h] = READY;
        pc_nxt[h] = ret_pc;
      end
      if (start_fire && start_idx == HW'(h)) begin
        st_nxt[h] = READY;
        pc_nxt[h] = dbg_start_pc;
      end
      if (dbg_halt_valid && dbg_halt_hart == 3'(h)) begin
        case (st_nxt[h])
          READY:    st_nxt[h] = IDLE;
          INFLIGHT: st_nxt[h] = HALTPEND;
          default:  ;
        endcase
      end
    end
  end

  // Pick -> issue register boundary
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int h = 0; h < HARTS; h++) begin
        st[h]      <= (h == 0) ? READY : IDLE;
        pc[h]      <= (h == 0) ? RESET_PC[23:0] : 24'd0;
        running[h] <= (h == 0);
      end
      for (int i = 0; i < RET_LAT; i++) begin
        src_vld[i]  <= 1'b0;
        src_hart[i] <= '0;
      end
      last_q      <= HW'(HARTS - 1);
      issue_valid <= 1'b0;
      issue_hpc   <= '0;
      collision   <= 1'b0;
      issue_count <= '0;
    end else begin
      for (int h = 0; h < HARTS; h++) begin
        st[h]      <= st_nxt[h];
        pc[h]      <= pc_nxt[h];
        running[h] <= (st_nxt[h] != IDLE);
      end
      src_vld[0]  <= pick_any;
      src_hart[0] <= pick_idx;
      for (int i = 1; i < RET_LAT; i++) begin
        src_vld[i]  <= src_vld[i-1];
        src_hart[i] <= src_hart[i-1];
      end
      if (pick_any)
        last_q <= pick_idx;
      issue_valid <= pick_any;
      issue_hpc   <= pick_any ? make_hpc(3'(pick_idx), pc[pick_idx]) : '0;
      if (ret_drop)
        collision <= 1'b1;
      if (issue_valid)
        issue_count <= issue_count + 32'd1;
    end
  end

endmodule
